// File: rtl/nios2_debug_ocimem_ctrl.sv
// Debug monitor RAM controller: serves decoded JTAG commands and an Avalon-MM
// CPU slave from one single-port 32-bit RAM, one access per cycle.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | accept pending/live JTAG command, else start a CPU request
// JRD   | JTAG read data returning: load MonDReg, bump jaddr
// CWR   | CPU write: waitrequest low, write enabled lanes if debugaccess
// CRD   | CPU read data returning: load cpu_readdata
// CRD2  | CPU read: waitrequest low, readdata presented
module nios2_debug_ocimem_ctrl #(
  parameter int ADDR_W = 8,
  parameter int INIT_Z = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [37:0]       jdo,
  input  logic              take_action_ocimem_a,
  input  logic              take_action_ocimem_b,
  input  logic              take_no_action_ocimem_a,
  input  logic [ADDR_W-1:0] cpu_address,
  input  logic              cpu_read,
  input  logic              cpu_write,
  input  logic [31:0]       cpu_writedata,
  input  logic [3:0]        cpu_byteenable,
  input  logic              cpu_debugaccess,
  output logic [31:0]       cpu_readdata,
  output logic              cpu_waitrequest,
  output logic [31:0]       MonDReg,
  output logic              monitor_ready,
  output logic              monitor_error
);
  localparam int DEPTH = 2 ** ADDR_W;

  typedef enum logic [2:0] {S_IDLE, S_JRD, S_CWR, S_CRD, S_CRD2} state_t;
  typedef enum logic [1:0] {C_NONE, C_LDA, C_WR, C_RD} cmd_t;

  // Only jdo[35:3] carries meaning: [35] clear flags, [34:3] data, [17+:ADDR_W] address.
  logic [32:0]       live_jf;
  logic              unused_jdo;
  cmd_t              live_cmd, exec_cmd, pend_cmd_q;
  logic              live_multi;
  logic [32:0]       exec_jf, pend_jf_q;
  logic              pend_q;
  state_t            state_q, state_d;
  logic [ADDR_W-1:0] jaddr_q;
  logic [31:0]       mon_q, rdata_q;
  logic              ready_q, error_q;

  logic [31:0]       mem [DEPTH];
  logic [31:0]       ram_q;
  logic [ADDR_W-1:0] ram_addr;
  logic [31:0]       ram_wdata;
  logic [3:0]        ram_be;
  logic              ram_re;

  logic pend_load, pend_clear, err_set, err_clr, rdy_set, rdy_clr;
  logic jaddr_ld, jaddr_inc, mon_ld, rdata_ld, wait_n;

  assign live_jf    = jdo[35:3];
  assign unused_jdo = ^{jdo[37:36], jdo[2:0]};
  assign live_multi = (take_action_ocimem_a & take_action_ocimem_b) |
                      (take_action_ocimem_a & take_no_action_ocimem_a) |
                      (take_action_ocimem_b & take_no_action_ocimem_a);

  // Priority encode the live JTAG pulses: a > b > no_action_a.
  always_comb begin
    live_cmd = C_NONE;
    if (take_action_ocimem_a)         live_cmd = C_LDA;
    else if (take_action_ocimem_b)    live_cmd = C_WR;
    else if (take_no_action_ocimem_a) live_cmd = C_RD;
  end

  // State register; reset aborts any access in flight.
  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state: JTAG work (pending first) beats a new CPU request in IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (exec_cmd == C_RD)        state_d = S_JRD;
        else if (exec_cmd != C_NONE) state_d = S_IDLE;
        else if (cpu_write)          state_d = S_CWR;
        else if (cpu_read)           state_d = S_CRD;
      end
      S_JRD:   state_d = S_IDLE;
      S_CWR:   state_d = S_IDLE;
      S_CRD:   state_d = S_CRD2;
      S_CRD2:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs: RAM port controls and datapath enables for the current state.
  always_comb begin
    exec_cmd   = C_NONE;
    exec_jf    = live_jf;
    ram_addr   = jaddr_q;
    ram_wdata  = live_jf[31:0];
    ram_be     = 4'h0;
    ram_re     = 1'b0;
    pend_load  = 1'b0;
    pend_clear = 1'b0;
    err_set    = live_multi;
    err_clr    = 1'b0;
    rdy_set    = 1'b0;
    rdy_clr    = 1'b0;
    jaddr_ld   = 1'b0;
    jaddr_inc  = 1'b0;
    mon_ld     = 1'b0;
    rdata_ld   = 1'b0;
    wait_n     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (pend_q) begin
          exec_cmd   = pend_cmd_q;
          exec_jf    = pend_jf_q;
          pend_load  = (live_cmd != C_NONE);
          pend_clear = (live_cmd == C_NONE);
        end else begin
          exec_cmd = live_cmd;
        end
        ram_wdata = exec_jf[31:0];
        case (exec_cmd)
          C_LDA: begin
            jaddr_ld = 1'b1;
            rdy_clr  = exec_jf[32];
            err_clr  = exec_jf[32];
          end
          C_WR: begin
            ram_be    = 4'hF;
            jaddr_inc = 1'b1;
          end
          C_RD: ram_re = 1'b1;
          default: begin
            if (!cpu_write && cpu_read) begin
              ram_re   = 1'b1;
              ram_addr = cpu_address;
            end
          end
        endcase
      end
      S_JRD: begin
        mon_ld    = 1'b1;
        jaddr_inc = 1'b1;
      end
      S_CWR: begin
        wait_n    = 1'b1;
        ram_addr  = cpu_address;
        ram_wdata = cpu_writedata;
        if (cpu_debugaccess) begin
          ram_be  = cpu_byteenable;
          rdy_set = (&cpu_address) & cpu_writedata[0];
        end
      end
      S_CRD:   rdata_ld = 1'b1;
      S_CRD2:  wait_n   = 1'b1;
      default: ;
    endcase
    if (state_q != S_IDLE && live_cmd != C_NONE) begin
      if (pend_q) err_set   = 1'b1;
      else        pend_load = 1'b1;
    end
  end

  // Datapath registers: jaddr, read-back registers, status flags, pending slot.
  always_ff @(posedge clk) begin
    if (reset) begin
      jaddr_q    <= '0;
      mon_q      <= '0;
      rdata_q    <= '0;
      ready_q    <= 1'b0;
      error_q    <= 1'b0;
      pend_q     <= 1'b0;
      pend_cmd_q <= C_NONE;
      pend_jf_q  <= '0;
    end else begin
      if (jaddr_ld)       jaddr_q <= exec_jf[14 +: ADDR_W];
      else if (jaddr_inc) jaddr_q <= jaddr_q + 1'b1;
      if (mon_ld)   mon_q   <= ram_q;
      if (rdata_ld) rdata_q <= ram_q;
      if (rdy_set)      ready_q <= 1'b1;
      else if (rdy_clr) ready_q <= 1'b0;
      if (err_set)      error_q <= 1'b1;
      else if (err_clr) error_q <= 1'b0;
      if (pend_load) begin
        pend_q     <= 1'b1;
        pend_cmd_q <= live_cmd;
        pend_jf_q  <= live_jf;
      end else if (pend_clear) begin
        pend_q <= 1'b0;
      end
    end
  end

  // RAM write port; nothing is written while reset is asserted.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (ram_be[0]) mem[ram_addr][7:0]   <= ram_wdata[7:0];
      if (ram_be[1]) mem[ram_addr][15:8]  <= ram_wdata[15:8];
      if (ram_be[2]) mem[ram_addr][23:16] <= ram_wdata[23:16];
      if (ram_be[3]) mem[ram_addr][31:24] <= ram_wdata[31:24];
    end
  end

  // Registered RAM read; optional zeroing keeps q defined before the first read.
  always_ff @(posedge clk) begin
    if (reset && INIT_Z != 0) ram_q <= '0;
    else if (ram_re)          ram_q <= mem[ram_addr];
  end

  assign cpu_readdata    = rdata_q;
  assign cpu_waitrequest = ~wait_n;
  assign MonDReg         = mon_q;
  assign monitor_ready   = ready_q;
  assign monitor_error   = error_q;
endmodule

// File: tb/tb_nios2_debug_ocimem_ctrl.sv
// Bench for nios2_debug_ocimem_ctrl: directed JTAG/CPU sequences, with CPU read
// data and MonDReg checked by a monitor against queued expectations.
module tb_nios2_debug_ocimem_ctrl;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [37:0] jdo = '0;
  logic        take_action_ocimem_a = 1'b0;
  logic        take_action_ocimem_b = 1'b0;
  logic        take_no_action_ocimem_a = 1'b0;
  logic [7:0]  cpu_address = '0;
  logic        cpu_read = 1'b0;
  logic        cpu_write = 1'b0;
  logic [31:0] cpu_writedata = '0;
  logic [3:0]  cpu_byteenable = '0;
  logic        cpu_debugaccess = 1'b0;
  logic [31:0] cpu_readdata;
  logic        cpu_waitrequest;
  logic [31:0] MonDReg;
  logic        monitor_ready;
  logic        monitor_error;

  int checks = 0;
  int errors = 0;
  logic [31:0] rdq[$];
  logic [31:0] monq[$];
  logic        rd_d1 = 1'b0, rd_d2 = 1'b0;

  localparam logic [2:0] P_A = 3'b001, P_B = 3'b010, P_R = 3'b100;

  nios2_debug_ocimem_ctrl #(.ADDR_W(8), .INIT_Z(1)) dut (
    .clk(clk), .reset(reset), .jdo(jdo),
    .take_action_ocimem_a(take_action_ocimem_a),
    .take_action_ocimem_b(take_action_ocimem_b),
    .take_no_action_ocimem_a(take_no_action_ocimem_a),
    .cpu_address(cpu_address), .cpu_read(cpu_read), .cpu_write(cpu_write),
    .cpu_writedata(cpu_writedata), .cpu_byteenable(cpu_byteenable),
    .cpu_debugaccess(cpu_debugaccess), .cpu_readdata(cpu_readdata),
    .cpu_waitrequest(cpu_waitrequest), .MonDReg(MonDReg),
    .monitor_ready(monitor_ready), .monitor_error(monitor_error)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Monitor: CPU read completions and MonDReg two edges after a JTAG read pulse.
  always @(negedge clk) begin
    if (cpu_read && !cpu_waitrequest) begin
      if (rdq.size() == 0) begin
        checks++; errors++;
        $display("FAIL cpu_rd_unexpected actual=%h expected=none", cpu_readdata);
      end else check("cpu_readdata", cpu_readdata, rdq.pop_front());
    end
    if (rd_d2) begin
      if (monq.size() == 0) begin
        checks++; errors++;
        $display("FAIL mondreg_unexpected actual=%h expected=none", MonDReg);
      end else check("MonDReg", MonDReg, monq.pop_front());
    end
    rd_d2 = rd_d1;
    rd_d1 = take_no_action_ocimem_a && !reset;
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic jtag(input logic [2:0] p, input logic [37:0] j);
    jdo = j;
    {take_no_action_ocimem_a, take_action_ocimem_b, take_action_ocimem_a} = p;
    @(posedge clk); #1;
    {take_no_action_ocimem_a, take_action_ocimem_b, take_action_ocimem_a} = 3'b000;
  endtask

  function automatic logic [37:0] j_addr(input logic [7:0] a, input logic clr);
    logic [37:0] v;
    v = '0;
    v[24:17] = a;
    v[35] = clr;
    return v;
  endfunction

  function automatic logic [37:0] j_data(input logic [31:0] d);
    logic [37:0] v;
    v = '0;
    v[34:3] = d;
    return v;
  endfunction

  task automatic cpu_wr(input logic [7:0] a, input logic [31:0] d, input logic [3:0] be, input logic dbg);
    int cyc;
    cyc = 0;
    cpu_address = a; cpu_writedata = d; cpu_byteenable = be; cpu_debugaccess = dbg;
    cpu_write = 1'b1;
    do begin @(negedge clk); cyc++; end while (cpu_waitrequest && cyc < 20);
    check("wr_latency", 32'(cyc), 32'd2);
    @(posedge clk); #1;
    cpu_write = 1'b0;
  endtask

  task automatic cpu_rd(input logic [7:0] a, input logic [31:0] exp);
    int cyc;
    cyc = 0;
    rdq.push_back(exp);
    cpu_address = a;
    cpu_read = 1'b1;
    do begin @(negedge clk); cyc++; end while (cpu_waitrequest && cyc < 20);
    check("rd_latency", 32'(cyc), 32'd3);
    @(posedge clk); #1;
    cpu_read = 1'b0;
  endtask

  initial begin
    // Reset values
    reset = 1'b1;
    idle(3);
    @(negedge clk);
    check("rst_MonDReg", MonDReg, 32'h0);
    check("rst_readdata", cpu_readdata, 32'h0);
    check("rst_waitreq", 32'(cpu_waitrequest), 32'd1);
    check("rst_ready", 32'(monitor_ready), 32'd0);
    check("rst_error", 32'(monitor_error), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    idle(1);

    // 1: load address, write, reload, JTAG read; jaddr ends at 0x11
    jtag(P_A, j_addr(8'h10, 1'b0));
    jtag(P_B, j_data(32'hDEADBEEF));
    jtag(P_A, j_addr(8'h10, 1'b0));
    monq.push_back(32'hDEADBEEF);
    jtag(P_R, '0);
    idle(2);
    jtag(P_B, j_data(32'hCAFE0011));
    cpu_rd(8'h11, 32'hCAFE0011);
    cpu_rd(8'h10, 32'hDEADBEEF);

    // 2: auto-increment wrap from 0xFF to 0x00
    jtag(P_A, j_addr(8'hFF, 1'b0));
    jtag(P_B, j_data(32'h1));
    jtag(P_B, j_data(32'h2));
    jtag(P_B, j_data(32'h3));
    cpu_rd(8'hFF, 32'h1);
    cpu_rd(8'h00, 32'h2);
    cpu_rd(8'h01, 32'h3);

    // 3: byte-lane CPU write, and a dropped write without debugaccess
    cpu_wr(8'h20, 32'hAAAAAAAA, 4'hF, 1'b1);
    cpu_wr(8'h20, 32'h12345678, 4'b0011, 1'b1);
    cpu_rd(8'h20, 32'hAAAA5678);
    cpu_wr(8'h20, 32'hFFFFFFFF, 4'hF, 1'b0);
    cpu_rd(8'h20, 32'hAAAA5678);

    // 4: JTAG writes arrive during a CPU read; second one overflows the slot
    cpu_wr(8'h30, 32'h11111111, 4'hF, 1'b1);
    jtag(P_A, j_addr(8'h30, 1'b0));
    check("err_before_collision", 32'(monitor_error), 32'd0);
    fork
      cpu_rd(8'h30, 32'h11111111);
      begin
        @(posedge clk); #1;
        jtag(P_B, j_data(32'h22222222));
        jtag(P_B, j_data(32'h33333333));
      end
    join
    idle(2);
    check("err_after_collision", 32'(monitor_error), 32'd1);
    jtag(P_B, j_data(32'h44444444));
    cpu_rd(8'h30, 32'h22222222);
    cpu_rd(8'h31, 32'h44444444);

    // 5: monitor_ready mailbox, multi-pulse collision with set-wins, clear
    cpu_wr(8'hFF, 32'h1, 4'hF, 1'b0);
    @(negedge clk);
    check("ready_no_dbg", 32'(monitor_ready), 32'd0);
    @(posedge clk); #1;
    cpu_wr(8'hFF, 32'h1, 4'hF, 1'b1);
    @(negedge clk);
    check("ready_set", 32'(monitor_ready), 32'd1);
    @(posedge clk); #1;
    jtag(P_A | P_B, j_addr(8'h40, 1'b1));
    @(negedge clk);
    check("multi_ready_clr", 32'(monitor_ready), 32'd0);
    check("multi_err_setwins", 32'(monitor_error), 32'd1);
    @(posedge clk); #1;
    jtag(P_B, j_data(32'h66));
    cpu_rd(8'h40, 32'h66);
    jtag(P_A, j_addr(8'h00, 1'b1));
    @(negedge clk);
    check("err_cleared", 32'(monitor_error), 32'd0);
    check("ready_still_clr", 32'(monitor_ready), 32'd0);
    @(posedge clk); #1;

    // 6a: reset during CWR suppresses the write
    cpu_wr(8'h60, 32'h12121212, 4'hF, 1'b1);
    cpu_address = 8'h60; cpu_writedata = 32'h99999999;
    cpu_byteenable = 4'hF; cpu_debugaccess = 1'b1; cpu_write = 1'b1;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0; cpu_write = 1'b0;
    idle(1);
    cpu_rd(8'h60, 32'h12121212);

    // 6b: reset with a pending JTAG write drops it and restores reset outputs
    cpu_wr(8'hFF, 32'h1, 4'hF, 1'b1);
    jtag(P_A, j_addr(8'h50, 1'b0));
    cpu_wr(8'h50, 32'h77777777, 4'hF, 1'b1);
    rdq.push_back(32'h77777777);
    cpu_address = 8'h50; cpu_read = 1'b1;
    @(posedge clk); #1;
    jtag(P_B, j_data(32'h88888888));
    reset = 1'b1;
    @(posedge clk); #1;
    cpu_read = 1'b0;
    @(negedge clk);
    check("rst2_MonDReg", MonDReg, 32'h0);
    check("rst2_readdata", cpu_readdata, 32'h0);
    check("rst2_waitreq", 32'(cpu_waitrequest), 32'd1);
    check("rst2_ready", 32'(monitor_ready), 32'd0);
    check("rst2_error", 32'(monitor_error), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    idle(3);
    cpu_rd(8'h00, 32'h2);
    cpu_rd(8'h50, 32'h77777777);
    check("err_after_rst", 32'(monitor_error), 32'd0);

    idle(3);
    check("rdq_drained", 32'(rdq.size()), 32'd0);
    check("monq_drained", 32'(monq.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
